// File: rtl/ifetch_prefetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue: datapath width,
// default depth, reset fetch address and the sequential PC step.
package ifetch_prefetch_queue_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam int          DEPTH_DEF    = 4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          PC_STEP      = 4;

endpackage

// File: rtl/ifetch_prefetch_queue_if.sv
// Handshake bundle around the prefetch queue: redirect input, imem request and
// response channels, and the decode-side output channel.
interface ifetch_prefetch_queue_if #(
   parameter int XLEN  = ifetch_prefetch_queue_pkg::XLEN_DEF,
   parameter int DEPTH = ifetch_prefetch_queue_pkg::DEPTH_DEF
);
   import ifetch_prefetch_queue_pkg::*;

   localparam int CW = $clog2(DEPTH + 1);

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_instr;
   logic [CW-1:0]   occupancy;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
      output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, occupancy
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
      input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, occupancy
   );

endinterface

// File: rtl/ifetch_prefetch_queue_fetch_fifo_ring.sv
// Ring buffer of {pc, instr} entries with push/pop and a synchronous clear that
// overrides both; storage is reset so the head reads as zero when empty.
module fetch_fifo_ring
   import ifetch_prefetch_queue_pkg::*;
#(
   parameter int W     = 2 * XLEN_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count
);

   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer increment wraps naturally
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: credit-limited in-order imem fetch, response
// buffering with PCs, and redirect flush with stale-response dropping.
module ifetch_prefetch_queue
   import ifetch_prefetch_queue_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter int              DEPTH    = DEPTH_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input logic                     clk,
   input logic                     rst_n,
   ifetch_prefetch_queue_if.master bus
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 1;

   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]     inflight_q, inflight_d;
   logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]     count;
   logic [2*XLEN-1:0] head;
   logic [XLEN-1:0]   redir_pc;
   logic              credit_ok, req_fire, rsp_stale, push, pop;

   assign redir_pc  = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign credit_ok = (SW'(count) + SW'(inflight_q)) < SW'(DEPTH);

   // Gated by rst_n so the request stays low during reset yet rises in the
   // very first cycle after release.
   assign bus.imem_req_valid = rst_n && credit_ok && !bus.redirect_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

   assign rsp_stale = drop_cnt_q != '0;
   assign push      = bus.imem_rsp_valid && !rsp_stale && !bus.redirect_valid;

   assign bus.out_valid = (count != '0) && !bus.redirect_valid;
   assign pop           = bus.out_valid && bus.out_ready;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_cnt_d = drop_cnt_q;
      inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.redirect_valid) begin
         // Everything still outstanding after this cycle belongs to the old path
         fetch_pc_d = redir_pc;
         rsp_pc_d   = redir_pc;
         drop_cnt_d = inflight_q - CW'(bus.imem_rsp_valid);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
         if (push)     rsp_pc_d   = rsp_pc_q + XLEN'(PC_STEP);
         if (bus.imem_rsp_valid && rsp_stale) drop_cnt_d = drop_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   fetch_fifo_ring #(
      .W     (2 * XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (bus.redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata ({rsp_pc_q, bus.imem_rsp_data}),
      .rdata (head),
      .count (count)
   );

   assign bus.out_pc    = head[2*XLEN-1:XLEN];
   assign bus.out_instr = head[XLEN-1:0];
   assign bus.occupancy = count;

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Directed and constrained-random bench for ifetch_prefetch_queue with an
// in-order imem model and a golden sequential-PC scoreboard on the output side.
module tb_ifetch_prefetch_queue;
   import ifetch_prefetch_queue_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ifetch_prefetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

   ifetch_prefetch_queue #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_pops  = 0;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } pend_t;

   pend_t       pq[$];
   int unsigned cyc      = 0;
   int unsigned last_due = 0;
   int          lat_lo   = 1;
   int          lat_hi   = 1;
   logic [31:0] exp_pc   = 32'h0;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'h5A5A_1234;
   endfunction

   initial begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_req_ready = 1'b0;
      bus.out_ready      = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
   end

   // Memory response driver: head of the pending list once its due cycle is reached
   always @(negedge clk) begin
      if (rst_n && pq.size() > 0 && pq[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = word(pq[0].addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
      end
   end

   // Pre-edge sampler: memory bookkeeping, output scoreboard, credit bound
   always begin
      @(negedge clk);
      #4;
      cyc++;
      if (!rst_n) begin
         pq.delete();
         last_due = 0;
         exp_pc   = 32'h0;
      end else begin
         n_tests++;
         if (int'(bus.occupancy) + pq.size() > DEPTH) begin
            n_fail++;
            $display("FAIL credit_bound occupancy=%0d inflight=%0d limit=%0d", bus.occupancy, pq.size(), DEPTH);
         end
         if (bus.redirect_valid) begin
            n_tests++;
            if (bus.out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL redirect_out_valid got=%b expected=0", bus.out_valid);
            end
            exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
         end else if (bus.out_valid && bus.out_ready) begin
            n_tests++;
            n_pops++;
            if (bus.out_pc !== exp_pc || bus.out_instr !== word(exp_pc)) begin
               n_fail++;
               $display("FAIL scoreboard pc=%h instr=%h expected pc=%h instr=%h",
                        bus.out_pc, bus.out_instr, exp_pc, word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
         if (bus.imem_rsp_valid) void'(pq.pop_front());
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            pend_t p;
            int unsigned d;
            d = cyc + 32'($urandom_range(lat_hi, lat_lo)) - 1;
            if (d < last_due) d = last_due;
            last_due = d;
            p.addr   = bus.imem_req_addr;
            p.due    = d;
            pq.push_back(p);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   // Leaves the caller at a falling edge with reset just released (window 0)
   task automatic apply_reset();
      @(negedge clk);
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_req_ready = 1'b0;
      bus.out_ready      = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      lat_lo = 1; lat_hi = 1;
      bus.imem_req_ready = 1'b1;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 32'h0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_req req_valid=%b addr=%h out_valid=%b expected 0/00000000/0",
                  bus.imem_req_valid, bus.imem_req_addr, bus.out_valid);
      end
      n_tests++;
      if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 || bus.occupancy !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_out pc=%h instr=%h occ=%0d expected 0/0/0",
                  bus.out_pc, bus.out_instr, bus.occupancy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_tests++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_first_req valid=%b addr=%h expected 1/00000000",
                  bus.imem_req_valid, bus.imem_req_addr);
      end
   endtask

   task automatic test_stream();
      lat_lo = 1; lat_hi = 1;
      apply_reset();
      bus.imem_req_ready = 1'b1;
      bus.out_ready      = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         n_tests++;
         if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'(4 * k)) begin
            n_fail++;
            $display("FAIL stream_req k=%0d valid=%b addr=%h expected 1/%h",
                     k, bus.imem_req_valid, bus.imem_req_addr, 32'(4 * k));
         end
         if (k >= 2) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * (k - 2))) begin
               n_fail++;
               $display("FAIL stream_out k=%0d valid=%b pc=%h expected 1/%h",
                        k, bus.out_valid, bus.out_pc, 32'(4 * (k - 2)));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      bus.out_ready = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      n_tests++;
      if (bus.occupancy !== 3'd4 || bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL backpressure occ=%0d req_valid=%b out_valid=%b expected 4/0/1",
                  bus.occupancy, bus.imem_req_valid, bus.out_valid);
      end
   endtask

   task automatic test_drain();
      @(negedge clk);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         n_tests++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h28 + 32'(4 * i)) begin
            n_fail++;
            $display("FAIL drain_out i=%0d valid=%b pc=%h expected 1/%h",
                     i, bus.out_valid, bus.out_pc, 32'h28 + 32'(4 * i));
         end
         if (i == 0) begin
            n_tests++;
            if (bus.imem_req_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL drain_no_credit req_valid=%b expected 0", bus.imem_req_valid);
            end
         end
         if (i == 1) begin
            n_tests++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h38) begin
               n_fail++;
               $display("FAIL drain_resume valid=%b addr=%h expected 1/00000038",
                        bus.imem_req_valid, bus.imem_req_addr);
            end
         end
      end
   endtask

   task automatic test_redirect();
      lat_lo = 4; lat_hi = 4;
      apply_reset();
      bus.imem_req_ready = 1'b1;
      repeat (2) @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0103;
      #1;
      n_tests++;
      if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL redirect_withdraw req_valid=%b out_valid=%b expected 0/0",
                  bus.imem_req_valid, bus.out_valid);
      end
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      #1;
      n_tests++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL redirect_target valid=%b addr=%h expected 1/00000100",
                  bus.imem_req_valid, bus.imem_req_addr);
      end
      for (int w = 4; w <= 7; w++) begin
         @(negedge clk);
         #1;
         n_tests++;
         if (bus.occupancy !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_drop w=%0d occ=%0d out_valid=%b expected 0/0",
                     w, bus.occupancy, bus.out_valid);
         end
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_instr !== word(32'h100)) begin
         n_fail++;
         $display("FAIL redirect_first valid=%b pc=%h instr=%h expected 1/00000100/%h",
                  bus.out_valid, bus.out_pc, bus.out_instr, word(32'h100));
      end
   endtask

   task automatic test_redirect_collision();
      lat_lo = 3; lat_hi = 3;
      apply_reset();
      bus.imem_req_ready = 1'b1;
      bus.out_ready      = 1'b1;
      repeat (5) @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0202;
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.imem_rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL collide_cycle out_valid=%b req_valid=%b rsp_valid=%b expected 0/0/1",
                  bus.out_valid, bus.imem_req_valid, bus.imem_rsp_valid);
      end
      n_tests++;
      if (bus.occupancy !== 3'd1 || bus.out_pc !== 32'h4) begin
         n_fail++;
         $display("FAIL collide_head occ=%0d pc=%h expected 1/00000004", bus.occupancy, bus.out_pc);
      end
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #1;
      n_tests++;
      if (bus.occupancy !== 3'd0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL collide_restart occ=%0d valid=%b addr=%h expected 0/1/00000200",
                  bus.occupancy, bus.imem_req_valid, bus.imem_req_addr);
      end
      for (int w = 7; w <= 9; w++) begin
         @(negedge clk);
         #1;
         n_tests++;
         if (bus.occupancy !== 3'd0) begin
            n_fail++;
            $display("FAIL collide_drop w=%0d occ=%0d expected 0", w, bus.occupancy);
         end
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_instr !== word(32'h200)) begin
         n_fail++;
         $display("FAIL collide_first valid=%b pc=%h instr=%h expected 1/00000200/%h",
                  bus.out_valid, bus.out_pc, bus.out_instr, word(32'h200));
      end
   endtask

   task automatic test_random();
      int pops0;
      lat_lo = 1; lat_hi = 4;
      apply_reset();
      pops0 = n_pops;
      for (int i = 0; i < 500; i++) begin
         if (i > 0) @(negedge clk);
         bus.imem_req_ready = ($urandom_range(0, 3) != 0);
         bus.out_ready      = ($urandom_range(0, 3) != 0);
         bus.redirect_valid = ($urandom_range(0, 19) == 0);
         bus.redirect_pc    = $urandom;
      end
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      bus.imem_req_ready = 1'b0;
      repeat (10) @(negedge clk);
      n_tests++;
      if (n_pops - pops0 < 50) begin
         n_fail++;
         $display("FAIL random_progress pops=%0d expected at least 50", n_pops - pops0);
      end
   endtask

   task automatic test_wrap();
      lat_lo = 1; lat_hi = 1;
      apply_reset();
      bus.imem_req_ready = 1'b1;
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFF8;
      #1;
      n_tests++;
      if (bus.imem_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_redirect req_valid=%b expected 0", bus.imem_req_valid);
      end
      for (int w = 1; w <= 5; w++) begin
         logic [31:0] ea, ep;
         @(negedge clk);
         bus.redirect_valid = 1'b0;
         #1;
         ea = 32'hFFFF_FFF8 + 32'(4 * (w - 1));
         ep = 32'hFFFF_FFF8 + 32'(4 * (w - 3));
         if (w <= 3) begin
            n_tests++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== ea) begin
               n_fail++;
               $display("FAIL wrap_req w=%0d valid=%b addr=%h expected 1/%h",
                        w, bus.imem_req_valid, bus.imem_req_addr, ea);
            end
         end
         if (w >= 3) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== ep || bus.out_instr !== word(ep)) begin
               n_fail++;
               $display("FAIL wrap_out w=%0d valid=%b pc=%h instr=%h expected 1/%h/%h",
                        w, bus.out_valid, bus.out_pc, bus.out_instr, ep, word(ep));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_drain();
      test_redirect();
      test_redirect_collision();
      test_random();
      test_wrap();
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
